// File: rtl/linear_layer_start_fifo_srl.sv
// Start-token FIFO between an upstream HLS process and a downstream PE.
// SRL-style storage: writes shift in at entry 0, reads select the oldest
// entry through an occupancy pointer; ap_fifo full_n/empty_n handshakes.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   if_full_n           : 1 = a write will be accepted
//   if_write_ce/if_write: write enable / request, if_din write data
//   if_empty_n          : 1 = if_dout holds the oldest valid entry
//   if_read_ce/if_read  : read enable / request
//   if_dout             : oldest entry, combinational from storage
//   if_num_data_valid   : registered occupancy, 0..DEPTH
module linear_layer_start_fifo_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  localparam int PW = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] PTR_EMPTY = '1;
  localparam logic [PW-1:0] PTR_ZERO  = '0;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_NFULL = PW'(DEPTH - 2);

  // Pointer to the oldest entry; all ones means empty.
  logic [PW-1:0] ptr_q, ptr_d;
  logic          full_n_q, full_n_d;
  logic          empty_n_q, empty_n_d;
  logic [PW-1:0] count_q, count_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic push;
  logic pop;

  logic [ADDR_WIDTH-1:0] rd_idx;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read & if_read_ce & empty_n_q;

  // Shift register: push moves every entry one slot older.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem_d[i] = mem_q[i-1];
      end
      mem_d[0] = if_din;
    end
  end

  // Pointer and flag update. Push+pop together keeps both unchanged;
  // the shift itself brings the next-oldest entry under the pointer.
  always_comb begin
    ptr_d     = ptr_q;
    full_n_d  = full_n_q;
    empty_n_d = empty_n_q;
    if (push && !pop) begin
      ptr_d     = ptr_q + PTR_ONE;
      empty_n_d = 1'b1;
      full_n_d  = (ptr_q != PTR_NFULL);
    end else if (pop && !push) begin
      ptr_d     = ptr_q - PTR_ONE;
      full_n_d  = 1'b1;
      empty_n_d = (ptr_q != PTR_ZERO);
    end
    count_d = ptr_d + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= PTR_EMPTY;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      count_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      count_q   <= count_d;
    end
  end

  // Storage is not reset; contents are logically discarded via ptr_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rd_idx = ptr_q[ADDR_WIDTH-1:0];

  // Out-of-range index only occurs while empty when DEPTH < 2**ADDR_WIDTH.
  always_comb begin
    if_dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == ADDR_WIDTH'(i)) begin
        if_dout = mem_q[i];
      end
    end
  end

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;

endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Directed bench for linear_layer_start_fifo_srl (DEPTH=4, 8-bit data).
module tb_linear_layer_start_fifo_srl;

  logic       clk;
  logic       reset;
  logic       if_full_n;
  logic       if_write_ce;
  logic       if_write;
  logic [7:0] if_din;
  logic       if_empty_n;
  logic       if_read_ce;
  logic       if_read;
  logic [7:0] if_dout;
  logic [2:0] if_num_data_valid;

  int checks = 0;
  int errors = 0;

  linear_layer_start_fifo_srl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(2),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_full_n(if_full_n),
    .if_write_ce(if_write_ce),
    .if_write(if_write),
    .if_din(if_din),
    .if_empty_n(if_empty_n),
    .if_read_ce(if_read_ce),
    .if_read(if_read),
    .if_dout(if_dout),
    .if_num_data_valid(if_num_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic fn, input logic en,
                    input logic [2:0] cnt);
    chk({tag, ".full_n"}, 32'(if_full_n), 32'(fn));
    chk({tag, ".empty_n"}, 32'(if_empty_n), 32'(en));
    chk({tag, ".count"}, 32'(if_num_data_valid), 32'(cnt));
  endtask

  initial begin
    reset = 1'b1;
    if_write_ce = 1'b1;
    if_write = 1'b0;
    if_din = 8'h00;
    if_read_ce = 1'b1;
    if_read = 1'b0;
    step();
    step();
    reset = 1'b0;
    st("reset", 1'b1, 1'b0, 3'd0);

    // Fill to full
    if_write = 1'b1;
    if_din = 8'h11; step();
    st("push1", 1'b1, 1'b1, 3'd1);
    chk("push1.dout", 32'(if_dout), 32'h11);
    if_din = 8'h22; step();
    st("push2", 1'b1, 1'b1, 3'd2);
    if_din = 8'h33; step();
    st("push3", 1'b1, 1'b1, 3'd3);
    if_din = 8'h44; step();
    st("push4", 1'b0, 1'b1, 3'd4);
    chk("push4.dout", 32'(if_dout), 32'h11);
    if_din = 8'h55; step();
    st("push5_ign", 1'b0, 1'b1, 3'd4);
    chk("push5.dout", 32'(if_dout), 32'h11);
    if_write = 1'b0;

    // Drain
    if_read = 1'b1;
    step();
    st("pop1", 1'b1, 1'b1, 3'd3);
    chk("pop1.dout", 32'(if_dout), 32'h22);
    step();
    st("pop2", 1'b1, 1'b1, 3'd2);
    chk("pop2.dout", 32'(if_dout), 32'h33);
    step();
    st("pop3", 1'b1, 1'b1, 3'd1);
    chk("pop3.dout", 32'(if_dout), 32'h44);
    step();
    st("pop4", 1'b1, 1'b0, 3'd0);
    step();
    st("pop5_ign", 1'b1, 1'b0, 3'd0);
    if_read = 1'b0;

    // Simultaneous push/pop with two entries
    if_write = 1'b1;
    if_din = 8'hA0; step();
    if_din = 8'hB0; step();
    st("two", 1'b1, 1'b1, 3'd2);
    chk("two.dout", 32'(if_dout), 32'hA0);
    if_din = 8'hC0;
    if_read = 1'b1;
    step();
    if_write = 1'b0;
    st("pushpop", 1'b1, 1'b1, 3'd2);
    chk("pushpop.dout", 32'(if_dout), 32'hB0);
    step();
    st("pp_pop1", 1'b1, 1'b1, 3'd1);
    chk("pp_pop1.dout", 32'(if_dout), 32'hC0);
    step();
    st("pp_pop2", 1'b1, 1'b0, 3'd0);
    if_read = 1'b0;

    // Clock-enable gating
    if_write = 1'b1;
    if_din = 8'h5A; step();
    st("ce_pre", 1'b1, 1'b1, 3'd1);
    if_write_ce = 1'b0;
    if_read_ce = 1'b0;
    if_read = 1'b1;
    if_din = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      st("ce_hold", 1'b1, 1'b1, 3'd1);
      chk("ce_hold.dout", 32'(if_dout), 32'h5A);
    end
    if_read = 1'b0;
    if_read_ce = 1'b1;
    if_write_ce = 1'b1;

    // Reset mid-operation with push active
    if_din = 8'h61; step();
    if_din = 8'h62; step();
    st("pre_rst", 1'b1, 1'b1, 3'd3);
    reset = 1'b1;
    if_din = 8'h77;
    step();
    reset = 1'b0;
    if_write = 1'b0;
    st("mid_rst", 1'b1, 1'b0, 3'd0);
    step();
    st("post_rst", 1'b1, 1'b0, 3'd0);
    if_write = 1'b1;
    if_din = 8'h88; step();
    if_write = 1'b0;
    st("post_rst_push", 1'b1, 1'b1, 3'd1);
    chk("post_rst.dout", 32'(if_dout), 32'h88);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
